phy_rx_nlane: RTL and testbench

PHY_RX_NLANE -- requirements
Module: phy_rx_nlane

---
 rtl/phy_rx_nlane.sv | 142 ++++++++++++++
 tb/tb_phy_rx_nlane.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_nlane.sv
// Multi-lane serial receiver: per-lane comma alignment, byte packing into lane
// words, and round-robin unstriping of lane words onto a single output.
module phy_rx_nlane #(
   parameter int         LANES    = 2,
   parameter int         WORD_W   = 32,
   parameter logic [7:0] COMMA    = 8'hBC,
   parameter int         SYNC_CNT = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [LANES-1:0]  data_in,
   output logic              valid_out,
   output logic [WORD_W-1:0] data_out,
   output logic [LANES-1:0]  active,
   output logic              err_out
);

   localparam int NB = WORD_W / 8;
   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] ST_HUNT  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   localparam logic [3:0]    SYNC_TGT = 4'(SYNC_CNT);
   localparam logic [3:0]    LAST_B   = 4'(NB - 1);
   localparam logic [PW-1:0] LAST_P   = PW'(LANES - 1);

   logic [1:0]        r_state  [LANES];
   logic [7:0]        r_shift  [LANES];
   logic [2:0]        r_bitcnt [LANES];
   logic [3:0]        r_ccnt   [LANES];
   logic [3:0]        r_bidx   [LANES];
   logic [WORD_W-1:0] r_word   [LANES];
   logic [WORD_W-1:0] r_buf    [LANES];
   logic [LANES-1:0]  r_full;
   logic [PW-1:0]     r_ptr;
   logic              r_valid;
   logic [WORD_W-1:0] r_data;
   logic              r_err;

   logic [7:0]        w_byte [LANES];
   logic [WORD_W-1:0] w_word [LANES];
   logic [LANES-1:0]  w_bnd;
   logic [LANES-1:0]  w_comma;
   logic [LANES-1:0]  w_lock;
   logic              w_drain;

   // Decisions use the byte including the bit sampled this edge, so a word
   // completes on the edge that samples its last bit.
   always_comb begin
      for (int unsigned k = 0; k < LANES; k++) begin
         w_byte[k]  = {r_shift[k][6:0], data_in[k]};
         w_word[k]  = (r_word[k] << 8) | WORD_W'(w_byte[k]);
         w_bnd[k]   = (r_bitcnt[k] == 3'd7);
         w_comma[k] = (w_byte[k] == COMMA);
         w_lock[k]  = (r_state[k] == ST_LOCK);
      end
   end

   assign w_drain   = (&w_lock) && r_full[r_ptr];
   assign active    = w_lock;
   assign valid_out = r_valid;
   assign data_out  = r_data;
   assign err_out   = r_err;

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            r_state[k]  <= ST_HUNT;
            r_shift[k]  <= '0;
            r_bitcnt[k] <= '0;
            r_ccnt[k]   <= '0;
            r_bidx[k]   <= '0;
            r_word[k]   <= '0;
            r_buf[k]    <= '0;
         end
         r_full  <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         for (int unsigned k = 0; k < LANES; k++) begin
            r_shift[k] <= w_byte[k];
            case (r_state[k])
               ST_HUNT: begin
                  if (w_comma[k]) begin
                     r_bitcnt[k] <= '0;
                     r_ccnt[k]   <= 4'd1;
                     r_bidx[k]   <= '0;
                     r_state[k]  <= (SYNC_TGT == 4'd1) ? ST_LOCK : ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  r_bitcnt[k] <= r_bitcnt[k] + 3'd1;
                  if (w_bnd[k]) begin
                     if (w_comma[k]) begin
                        r_ccnt[k] <= r_ccnt[k] + 4'd1;
                        if (r_ccnt[k] + 4'd1 == SYNC_TGT) r_state[k] <= ST_LOCK;
                     end else begin
                        r_ccnt[k]  <= '0;
                        r_state[k] <= ST_HUNT;
                     end
                  end
               end
               ST_LOCK: begin
                  r_bitcnt[k] <= r_bitcnt[k] + 3'd1;
                  if (w_bnd[k]) begin
                     if (w_comma[k]) begin
                        if (r_bidx[k] != 4'd0) r_err <= 1'b1;
                        r_bidx[k] <= '0;
                     end else if (r_bidx[k] == LAST_B) begin
                        r_bidx[k] <= '0;
                        if (!r_full[k]) begin
                           r_buf[k]  <= w_word[k];
                           r_full[k] <= 1'b1;
                        end else begin
                           r_err <= 1'b1;
                        end
                     end else begin
                        r_word[k] <= w_word[k];
                        r_bidx[k] <= r_bidx[k] + 4'd1;
                     end
                  end
               end
               default: r_state[k] <= ST_HUNT;
            endcase
         end
         // Drain needs full while load needs empty, so they never hit one lane together.
         if (w_drain) begin
            r_data        <= r_buf[r_ptr];
            r_valid       <= 1'b1;
            r_full[r_ptr] <= 1'b0;
            r_buf[r_ptr]  <= '0;
            r_ptr         <= (r_ptr == LAST_P) ? '0 : r_ptr + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_phy_rx_nlane.sv
// Bench for phy_rx_nlane (LANES=2, WORD_W=32): byte-slot stimulus on both lanes
// with a scoreboard of expected words and their expected output cycles.
module tb_phy_rx_nlane;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  data_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic [1:0]  active;
   logic        err_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] word;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   phy_rx_nlane #(.LANES(2), .WORD_W(32), .COMMA(8'hBC), .SYNC_CNT(4)) dut (
      .clk_32f   (clk),
      .reset     (rst),
      .data_in   (data_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .active    (active),
      .err_out   (err_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every pulse must match the oldest expected word and its cycle.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: data_out=%h at cycle %0d, none expected", data_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (data_out !== e.word) begin
               errors++;
               $display("FAIL sb_word: got %h expected %h", data_out, e.word);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL sb_latency: word %h at cycle %0d expected cycle %0d", e.word, cyc, e.cyc);
            end
         end
      end
   end

   task automatic send_slot(input logic [7:0] b0, input logic [7:0] b1);
      for (int i = 7; i >= 0; i--) begin
         data_in[0] = b0[i];
         data_in[1] = b1[i];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] w, input int c);
      exp_t e;
      e.word = w;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      data_in = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic lock_both();
      repeat (4) send_slot(8'hBC, 8'hBC);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      data_in = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
      checks++; if (active !== 2'b00) begin errors++; $display("FAIL reset_active: got %b expected 00", active); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_out); end
      rst = 1'b0;
   endtask

   task automatic test_lock();
      send_slot(8'hBC, 8'hBC);
      send_slot(8'hBC, 8'hBC);
      send_slot(8'hBC, 8'hBC);
      checks++; if (active !== 2'b00) begin errors++; $display("FAIL lock_3comma: got %b expected 00", active); end
      send_slot(8'h00, 8'hBC);
      checks++; if (active !== 2'b10) begin errors++; $display("FAIL lock_lane1: got %b expected 10", active); end
      repeat (3) send_slot(8'hBC, 8'hBC);
      checks++; if (active !== 2'b10) begin errors++; $display("FAIL lock_lane0_early: got %b expected 10", active); end
      send_slot(8'hBC, 8'hBC);
      checks++; if (active !== 2'b11) begin errors++; $display("FAIL lock_both: got %b expected 11", active); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL lock_err: got %b expected 0", err_out); end
   endtask

   task automatic test_unstripe();
      send_slot(8'h11, 8'h55);
      send_slot(8'h22, 8'h66);
      send_slot(8'h33, 8'h77);
      send_slot(8'h44, 8'h88);
      push_exp(32'h11223344, cyc + 1);
      push_exp(32'h55667788, cyc + 2);
      send_slot(8'hBC, 8'hBC);
   endtask

   task automatic test_order();
      send_slot(8'hBC, 8'hA5);
      send_slot(8'h12, 8'hA6);
      send_slot(8'h34, 8'hA7);
      send_slot(8'h56, 8'hA8);
      send_slot(8'h78, 8'hBC);
      push_exp(32'h12345678, cyc + 1);
      push_exp(32'hA5A6A7A8, cyc + 2);
      send_slot(8'hBC, 8'hBC);
   endtask

   task automatic test_partial_err();
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL partial_err_before: got %b expected 0", err_out); end
      send_slot(8'hAA, 8'hBC);
      send_slot(8'hBB, 8'hBC);
      send_slot(8'hBC, 8'hBC);
      checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL partial_err_set: got %b expected 1", err_out); end
      send_slot(8'h01, 8'h05);
      send_slot(8'h02, 8'h06);
      send_slot(8'h03, 8'h07);
      send_slot(8'h04, 8'h08);
      push_exp(32'h01020304, cyc + 1);
      push_exp(32'h05060708, cyc + 2);
      send_slot(8'hBC, 8'hBC);
      checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL partial_err_sticky: got %b expected 1", err_out); end
   endtask

   task automatic test_drop();
      apply_reset();
      lock_both();
      checks++; if (active !== 2'b11) begin errors++; $display("FAIL drop_relock: got %b expected 11", active); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL drop_err_before: got %b expected 0", err_out); end
      send_slot(8'hBC, 8'hA1);
      send_slot(8'hBC, 8'hA2);
      send_slot(8'hBC, 8'hA3);
      send_slot(8'hBC, 8'hA4);
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL drop_err_first: got %b expected 0", err_out); end
      send_slot(8'hBC, 8'hB1);
      send_slot(8'hBC, 8'hB2);
      send_slot(8'hBC, 8'hB3);
      send_slot(8'hBC, 8'hB4);
      checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b expected 1", err_out); end
      send_slot(8'hC1, 8'hBC);
      send_slot(8'hC2, 8'hBC);
      send_slot(8'hC3, 8'hBC);
      send_slot(8'hC4, 8'hBC);
      push_exp(32'hC1C2C3C4, cyc + 1);
      push_exp(32'hA1A2A3A4, cyc + 2);
      send_slot(8'hBC, 8'hBC);
   endtask

   task automatic test_reset_mid();
      send_slot(8'h11, 8'h55);
      send_slot(8'h22, 8'h66);
      rst = 1'b1;
      #1;
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 00000000", data_out); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid_out); end
      checks++; if (active !== 2'b00) begin errors++; $display("FAIL rstmid_active: got %b expected 00", active); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err_out); end
      data_in = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      send_slot(8'h33, 8'h33);
      send_slot(8'h44, 8'h44);
      checks++; if (active !== 2'b00) begin errors++; $display("FAIL rstmid_unlocked: got %b expected 00", active); end
      lock_both();
      checks++; if (active !== 2'b11) begin errors++; $display("FAIL rstmid_relock: got %b expected 11", active); end
      send_slot(8'hD1, 8'hE1);
      send_slot(8'hD2, 8'hE2);
      send_slot(8'hD3, 8'hE3);
      send_slot(8'hD4, 8'hE4);
      push_exp(32'hD1D2D3D4, cyc + 1);
      push_exp(32'hE1E2E3E4, cyc + 2);
      send_slot(8'hBC, 8'hBC);
      send_slot(8'hBC, 8'hBC);
   endtask

   initial begin
      rst = 1'b1;
      data_in = 2'b00;
      @(posedge clk);
      #1;
      test_reset();
      test_lock();
      test_unstripe();
      test_order();
      test_partial_err();
      test_drop();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d words never output, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
